// File: rtl/change_dispenser.sv
// change_dispenser: greedy change payout with a dry-run feasibility pass.
// Ports: clk, reset (async, active-low), start/change_amount request,
//   coin_valid/coin_out/coin_ack payout handshake, refill/refill_coin,
//   busy/done/error/remaining status, count_* per-denomination inventory.
module change_dispenser #(
  parameter logic [3:0] INIT_COUNT = 4'd10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] change_amount,
  input  logic        coin_ack,
  input  logic        refill,
  input  logic [1:0]  refill_coin,
  output logic        coin_valid,
  output logic [1:0]  coin_out,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] remaining,
  output logic [3:0]  count_500,
  output logic [3:0]  count_1000,
  output logic [3:0]  count_2000,
  output logic [3:0]  count_5000
);

  typedef enum logic [1:0] {
    IDLE, CHECK, DISPENSE, FINISH
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rem_q, shrem_q;
  logic [3:0]  cnt_q   [4];
  logic [3:0]  shcnt_q [4];
  logic        err_q;

  logic        ld, sh_step, take, err_set;
  logic        refill_ok;
  logic [2:0]  g_sh, g_rl;
  logic [15:0] v_sh, v_rl;

  function automatic logic [15:0] val(
    input logic [1:0] d
  );
    unique case (d)
      2'd0: return 16'd500;
      2'd1: return 16'd1000;
      2'd2: return 16'd2000;
      2'd3: return 16'd5000;
    endcase
  endfunction

  // {found, denom}: largest stocked coin not above r.
  function automatic logic [2:0] greedy(
    input logic [15:0] r,
    input logic [3:0]  c0,
    input logic [3:0]  c1,
    input logic [3:0]  c2,
    input logic [3:0]  c3
  );
    if (c3 != 4'd0 && r >= 16'd5000)
      return 3'b111;
    if (c2 != 4'd0 && r >= 16'd2000)
      return 3'b110;
    if (c1 != 4'd0 && r >= 16'd1000)
      return 3'b101;
    if (c0 != 4'd0 && r >= 16'd500)
      return 3'b100;
    return 3'b000;
  endfunction

  assign g_sh = greedy(shrem_q, shcnt_q[0],
    shcnt_q[1], shcnt_q[2], shcnt_q[3]);
  assign g_rl = greedy(rem_q, cnt_q[0],
    cnt_q[1], cnt_q[2], cnt_q[3]);
  assign v_sh = val(g_sh[1:0]);
  assign v_rl = val(g_rl[1:0]);

  assign refill_ok = (state_q == IDLE)
    && !start && refill;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    coin_valid = 1'b0;
    coin_out   = 2'b00;
    busy       = 1'b1;
    done       = 1'b0;
    ld         = 1'b0;
    sh_step    = 1'b0;
    take       = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          ld      = 1'b1;
          state_d = (change_amount == 16'd0)
            ? FINISH : CHECK;
        end
      end
      CHECK: begin
        if (shrem_q == 16'd0) begin
          state_d = DISPENSE;
        end else if (g_sh[2]) begin
          sh_step = 1'b1;
        end else begin
          err_set = 1'b1;
          state_d = FINISH;
        end
      end
      DISPENSE: begin
        coin_valid = g_rl[2];
        coin_out   = g_rl[1:0];
        if (coin_valid && coin_ack) begin
          take = 1'b1;
          if (rem_q == v_rl)
            state_d = FINISH;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q   <= 16'd0;
      shrem_q <= 16'd0;
      err_q   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i]   <= INIT_COUNT;
        shcnt_q[i] <= INIT_COUNT;
      end
    end else begin
      if (ld) begin
        rem_q   <= change_amount;
        shrem_q <= change_amount;
        err_q   <= 1'b0;
        for (int i = 0; i < 4; i++)
          shcnt_q[i] <= cnt_q[i];
      end
      if (err_set)
        err_q <= 1'b1;
      if (sh_step) begin
        shrem_q <= shrem_q - v_sh;
        shcnt_q[g_sh[1:0]] <=
          shcnt_q[g_sh[1:0]] - 4'd1;
      end
      if (take) begin
        rem_q <= rem_q - v_rl;
        cnt_q[g_rl[1:0]] <=
          cnt_q[g_rl[1:0]] - 4'd1;
      end
      if (refill_ok
          && cnt_q[refill_coin] != 4'd15)
        cnt_q[refill_coin] <=
          cnt_q[refill_coin] + 4'd1;
    end
  end

  assign error      = done & err_q;
  assign remaining  = rem_q;
  assign count_500  = cnt_q[0];
  assign count_1000 = cnt_q[1];
  assign count_2000 = cnt_q[2];
  assign count_5000 = cnt_q[3];

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser: scoreboard bench for change_dispenser.
// Directed requests push expected coins/completions; a monitor checks them.
module tb_change_dispenser;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] change_amount = 16'd0;
  logic        coin_ack = 1'b0;
  logic        refill = 1'b0;
  logic [1:0]  refill_coin = 2'b00;
  logic        coin_valid;
  logic [1:0]  coin_out;
  logic        busy, done, error;
  logic [15:0] remaining;
  logic [3:0]  count_500, count_1000;
  logic [3:0]  count_2000, count_5000;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          is_done;
    logic [1:0]  coin;
    bit          err;
    logic [15:0] rem;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start),
    .change_amount(change_amount),
    .coin_ack(coin_ack), .refill(refill),
    .refill_coin(refill_coin),
    .coin_valid(coin_valid), .coin_out(coin_out),
    .busy(busy), .done(done), .error(error),
    .remaining(remaining),
    .count_500(count_500), .count_1000(count_1000),
    .count_2000(count_2000), .count_5000(count_5000)
  );

  task automatic chk(input string name,
                     input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp_v);
    end
  endtask

  task automatic push_coin(input logic [1:0] c);
    exp_t e;
    e.is_done = 1'b0; e.coin = c;
    e.err = 1'b0; e.rem = 16'd0;
    q.push_back(e);
  endtask

  task automatic push_done(input bit err,
                           input logic [15:0] rem);
    exp_t e;
    e.is_done = 1'b1; e.coin = 2'b00;
    e.err = err; e.rem = rem;
    q.push_back(e);
  endtask

  task automatic chk_counts(input int c0, input int c1,
                            input int c2, input int c3);
    chk("count_500", count_500, c0);
    chk("count_1000", count_1000, c1);
    chk("count_2000", count_2000, c2);
    chk("count_5000", count_5000, c3);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0;
    coin_ack = 1'b0; refill = 1'b0;
    q.delete();
    #1;
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_coin_out", coin_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_remaining", remaining, 0);
    chk_counts(10, 10, 10, 10);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic send_start(input logic [15:0] amt);
    change_amount = amt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        @(posedge clk); #1;
        return;
      end
    end
    chk("done_timeout", done, 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (coin_valid) return;
    end
    chk("valid_timeout", coin_valid, 1);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (coin_valid) begin
        if (q.size() == 0 || q[0].is_done)
          chk("stray_coin", coin_valid, 0);
        else if (coin_ack) begin
          m_e = q.pop_front();
          chk("coin_out", coin_out, m_e.coin);
        end
      end
      if (done) begin
        if (q.size() == 0 || !q[0].is_done)
          chk("stray_done", done, 0);
        else begin
          m_e = q.pop_front();
          chk("error", error, m_e.err);
          chk("done_remaining", remaining, m_e.rem);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  initial begin
    int n;
    #2;
    do_reset();

    // 7500 with ack tied high: 5000, 2000, 500
    coin_ack = 1'b1;
    push_coin(2'b11); push_coin(2'b10);
    push_coin(2'b00); push_done(1'b0, 16'd0);
    send_start(16'd7500);
    chk("busy_after_start", busy, 1);
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (coin_valid) break;
      n++;
      @(posedge clk);
    end
    chk("check_latency", n, 4);
    wait_done();
    chk("busy_after_done", busy, 0);
    chk("remaining_7500", remaining, 0);
    chk_counts(9, 10, 9, 9);
    coin_ack = 1'b0;

    // 3000 with stalled ack; refill held while busy
    do_reset();
    push_coin(2'b10); push_coin(2'b01);
    push_done(1'b0, 16'd0);
    refill = 1'b1; refill_coin = 2'b01;
    send_start(16'd3000);
    wait_valid();
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", coin_valid, 1);
      chk("hold_coin", coin_out, 2);
      @(posedge clk); #1;
      if (i == 2) coin_ack = 1'b1;
      @(negedge clk);
    end
    chk("hold_coin4", coin_out, 2);
    wait_done();
    refill = 1'b0;
    coin_ack = 1'b0;
    chk_counts(10, 9, 9, 10);

    // 750 is not a multiple of 500: rejected
    coin_ack = 1'b1;
    push_done(1'b1, 16'd750);
    send_start(16'd750);
    wait_done();
    chk("remaining_750", remaining, 750);
    chk_counts(10, 9, 9, 10);
    coin_ack = 1'b0;

    // zero request
    push_done(1'b0, 16'd0);
    send_start(16'd0);
    @(negedge clk);
    chk("zero_done", done, 1);
    @(posedge clk); #1;
    chk("zero_busy", busy, 0);

    // 50000 drains the 5000s, then 5000 from smaller coins
    do_reset();
    coin_ack = 1'b1;
    for (int i = 0; i < 10; i++) push_coin(2'b11);
    push_done(1'b0, 16'd0);
    send_start(16'd50000);
    wait_done();
    chk_counts(10, 10, 10, 0);
    push_coin(2'b10); push_coin(2'b10);
    push_coin(2'b01); push_done(1'b0, 16'd0);
    send_start(16'd5000);
    wait_done();
    chk_counts(10, 9, 8, 0);

    // exhaustion: no 1000s, one 500 left
    do_reset();
    coin_ack = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_coin(2'b01); push_done(1'b0, 16'd0);
      send_start(16'd1000);
      wait_done();
    end
    for (int i = 0; i < 9; i++) begin
      push_coin(2'b00); push_done(1'b0, 16'd0);
      send_start(16'd500);
      wait_done();
    end
    chk_counts(1, 0, 10, 10);
    push_done(1'b1, 16'd1000);
    send_start(16'd1000);
    wait_done();
    chk_counts(1, 0, 10, 10);
    coin_ack = 1'b0;

    // refill saturation
    do_reset();
    refill = 1'b1; refill_coin = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("refill_5000", count_5000,
          (11 + i > 15) ? 15 : 11 + i);
    end
    refill = 1'b0;

    // reset after the first ack of 7500
    do_reset();
    coin_ack = 1'b1;
    push_coin(2'b11);
    send_start(16'd7500);
    wait_valid();
    @(posedge clk); #1;
    chk("first_ack_5000", count_5000, 9);
    chk("next_coin_valid", coin_valid, 1);
    reset = 1'b0;
    #1;
    chk("async_valid_drop", coin_valid, 0);
    chk("async_busy", busy, 0);
    chk_counts(10, 10, 10, 10);
    coin_ack = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/change_dispenser.md
# change_dispenser

Dispenses change to the customer as a sequence of physical coins/notes, one per handshake, from a per-denomination inventory. Sits on the payout side of the vending datapath, opposite the coin-acceptance counter. It uses the same 2-bit denomination encoding (00=500, 01=1000, 10=2000, 11=5000). Before releasing anything it runs a greedy dry-run, so a request is either paid in full or rejected with no coins emitted.

## Interface
- INIT_COUNT, 4'd10, units of each denomination loaded at reset.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- start  in  1  request strobe, sampled in IDLE only.
- change_amount  in  16  amount to pay out, sampled with start.
- coin_ack  in  1  payout mechanism has taken the presented coin.
- refill  in  1  add one unit of refill_coin to inventory (IDLE only).
- refill_coin  in  2  denomination of refill.
- coin_valid  out  1  coin_out is presented.
- coin_out  out  2  denomination being presented.
- busy  out  1  request in progress; start ignored.
- done  out  1  one-cycle completion pulse.
- error  out  1  valid with done; 1 = request rejected.
- remaining  out  16  amount still owed in the current request.
- count_500, count_1000, count_2000, count_5000  out  4 each  current inventory.

## Operation
- States: IDLE, CHECK, DISPENSE, FINISH.
- IDLE:
  - start=1 latches change_amount into remaining and the shadow remainder, copies counts into shadow counts, and goes to CHECK.
  - If change_amount=0, goes to FINISH instead, with error=0.
- Greedy rule, used identically in CHECK and DISPENSE: pick the largest denomination d with count[d]>0 and d<=remainder.
- CHECK: one shadow coin per cycle; subtract d from the shadow remainder and decrement the shadow count. Exits:
  - shadow remainder=0: go to DISPENSE.
  - No eligible d and shadow remainder>0: go to FINISH with error=1.
  - A non-multiple of 500 always ends this way.
- DISPENSE:
  - Present the greedy coin: coin_valid=1, coin_out=d.
  - On coin_valid&&coin_ack: count[d] decrements and remaining -= d.
  - Next cycle presents the next coin; if remaining=0, go to FINISH with error=0.
  - Without ack, coin_out and coin_valid hold unchanged.
- FINISH: done=1 (and error per outcome) for exactly one cycle, then IDLE.
  - On error, counts and remaining are untouched, so remaining keeps the requested amount.
- busy=1 in CHECK, DISPENSE and FINISH.
- Refill:
  - Accepted only in IDLE and only when start=0; start has priority.
  - Increments count[refill_coin], saturating at 15.
  - Ignored in every other state.
- All arithmetic is 16-bit unsigned. remaining never underflows because d<=remaining by construction.

## Timing
- Reset (async, on falling edge of reset, while low):
  - state=IDLE, coin_valid=0, coin_out=00, busy=0, done=0, error=0, remaining=0.
  - All counts=INIT_COUNT.
- Reset mid-operation: coin_valid drops immediately (asynchronously); in-flight coin is not counted; inventory is reloaded.
- Start sampled at edge 0: busy=1 after edge 0; CHECK occupies N+1 cycles for N coins.
- Dispense:
  - First coin_valid appears the cycle after CHECK ends.
  - With coin_ack held high, one coin per cycle back-to-back.
  - Count updates are visible the cycle after the acking edge.
- coin_ack while coin_valid=0 is ignored.
- done follows the final ack by one cycle; busy falls with done.
- A new start is accepted the cycle after done.
- Zero request: done=1 one cycle after start, no coin_valid.

## Test plan
- Reset, start with 7500, ack tied high -> coins 11, 10, 00 on consecutive cycles; done=1, error=0; counts 500/1000/2000/5000 = 9/10/9/9; remaining=0.
- Start with 3000, coin_ack low for 3 cycles -> coin_out=10 held valid 4 cycles; then 01 after ack; done pulse; count_2000=9, count_1000=9.
- Start with 750 -> done=1 with error=1; coin_valid never asserts; counts unchanged; remaining=750.
- Start with 50000 -> ten 11 coins, count_5000=0; then start with 5000 -> 10, 10, 01; error=0.
- Exhaustion: from reset set count_500=1 via dispensing, then request 1000 with count_1000=0, count_2000 irrelevant -> greedy fails -> error=1, no coins.
- Refill and reset:
  - refill_coin=11 held 6 cycles in IDLE -> count_5000 saturates at 15.
  - Refill asserted while busy -> no change.
  - Reset low after the first ack of 7500 -> coin_valid=0 at once; counts back to 10.
  - start with 0 -> done next cycle, error=0.
